// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Bits needed to hold values 0..lat inclusive.
  function automatic int MEM_LAT_W(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_lat_timer.sv
// Memory latency down-counter: loads MEM_LAT-1, decrements while enabled, flags zero.
module mem_arb_lat_timer
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CNT_W = MEM_LAT_W(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (load) begin
      cnt_d = CNT_INIT;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency unified memory between IF and MEM pipeline ports.
// Optional IF starvation guard enabled by defining MEMARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT      = 3,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        iClkCPU,
  input  logic        iRST,
  input  logic        iIReq,
  input  logic [31:0] iIAddr,
  input  logic        iIFlush,
  output logic [31:0] oIRData,
  output logic        oIDone,
  input  logic        iDReq,
  input  logic        iDWE,
  input  logic [31:0] iDAddr,
  input  logic [31:0] iDWData,
  output logic [31:0] oDRData,
  output logic        oDDone,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic        oMemRE,
  output logic        oMemWE,
  input  logic [31:0] iMemRData,
  output logic        oStallIF,
  output logic        oStallMEM
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic        we_q, we_d;
  logic        cancel_q, cancel_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;

  logic ireq_ok, gnt_data, gnt_inst, starve_i, flush_hit;
  logic timer_load, timer_dec, lat_expired;

  assign ireq_ok    = iIReq & ~iIFlush;
  assign flush_hit  = (owner_q == OWN_I) & iIFlush;
  assign timer_load = (state_q == ISSUE);
  assign timer_dec  = (state_q == WAIT);

  mem_arb_lat_timer #(.MEM_LAT(MEM_LAT)) u_lat_timer (
    .clk     (iClkCPU),
    .rst_n   (iRST),
    .load    (timer_load),
    .dec     (timer_dec),
    .expired (lat_expired)
  );

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int STREAK_W = MEM_LAT_W(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  assign starve_i = ireq_ok & (streak_q == STREAK_MAX);

  // Streak only moves on IDLE decisions; a waiting IF is what makes a D grant count.
  always_comb begin
    if (state_q != IDLE) begin
      streak_d = streak_q;
    end else if (gnt_inst || !ireq_ok) begin
      streak_d = {STREAK_W{1'b0}};
    end else if (gnt_data && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  always_ff @(posedge iClkCPU) begin
    if (!iRST) begin
      streak_q <= {STREAK_W{1'b0}};
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign starve_i = 1'b0;
`endif

  // Data side wins ties: it belongs to the older instruction in the pipeline.
  assign gnt_data = iDReq & ~starve_i;
  assign gnt_inst = ~gnt_data & ireq_ok;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cancel_d    = cancel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (gnt_data) begin
          state_d     = ISSUE;
          owner_d     = OWN_D;
          we_d        = iDWE;
          mem_addr_d  = iDAddr;
          mem_wdata_d = iDWData;
          mem_re_d    = ~iDWE;
          mem_we_d    = iDWE;
        end else if (gnt_inst) begin
          state_d    = ISSUE;
          owner_d    = OWN_I;
          we_d       = 1'b0;
          mem_addr_d = iIAddr;
          mem_re_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        cancel_d = cancel_q | flush_hit;
      end
      WAIT: begin
        cancel_d = cancel_q | flush_hit;
        if (lat_expired) begin
          state_d = DONE;
          if (owner_q == OWN_D) begin
            d_done_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = iMemRData;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else if (!(cancel_q || iIFlush)) begin
            i_done_d  = 1'b1;
            i_rdata_d = iMemRData;
          end else begin
            i_done_d = 1'b0;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d  = IDLE;
        cancel_d = cancel_q | flush_hit;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClkCPU) begin
    if (!iRST) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      we_q        <= 1'b0;
      cancel_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      i_rdata_q   <= 32'h0000_0000;
      d_rdata_q   <= 32'h0000_0000;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cancel_q    <= cancel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
    end
  end

  assign oIRData   = i_rdata_q;
  assign oIDone    = i_done_q;
  assign oDRData   = d_rdata_q;
  assign oDDone    = d_done_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemWData = mem_wdata_q;
  assign oMemRE    = mem_re_q;
  assign oMemWE    = mem_we_q;
  assign oStallIF  = iIReq & ~i_done_q & ~iIFlush;
  assign oStallMEM = iDReq & ~d_done_q;

endmodule
